// File: rtl/sub_pkg.sv
// Shared widths and pipeline depth for the 8-bit borrow-lookahead subtractor.
package sub_pkg;
    localparam int DATA_W     = 8;
    localparam int NIB_W      = 4;
    localparam int PIPE_DEPTH = 2;
endpackage

// File: rtl/sub4_lookahead.sv
// Combinational 4-bit subtractor built from gate primitives with a flat borrow-lookahead network.
module sub4_lookahead
    import sub_pkg::*;
#(
    parameter int PwrC = 0
) (
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             bi,
    output logic [NIB_W-1:0] d,
    output logic             bo
);
    logic [NIB_W-1:0] na_s;
    logic [NIB_W-1:0] g_s;
    logic [NIB_W-1:0] p_s;
    logic [NIB_W-1:0] bw_s;
    logic [NIB_W-1:0] bin_s;
    logic t0a_s, t1a_s, t1b_s, t2a_s, t2b_s, t2c_s;
    logic t3a_s, t3b_s, t3c_s, t3d_s;

    for (genvar k = 0; k < NIB_W; k++) begin : g_gp
        not u_na (na_s[k], a[k]);
        and u_g  (g_s[k], na_s[k], b[k]);
        or  u_p  (p_s[k], na_s[k], b[k]);
    end

    // Each borrow is expanded to a sum of products so no bit waits on its neighbour.
    and u_t0a (t0a_s, p_s[0], bi);
    or  u_b0  (bw_s[0], g_s[0], t0a_s);
    and u_t1a (t1a_s, p_s[1], g_s[0]);
    and u_t1b (t1b_s, p_s[1], p_s[0], bi);
    or  u_b1  (bw_s[1], g_s[1], t1a_s, t1b_s);
    and u_t2a (t2a_s, p_s[2], g_s[1]);
    and u_t2b (t2b_s, p_s[2], p_s[1], g_s[0]);
    and u_t2c (t2c_s, p_s[2], p_s[1], p_s[0], bi);
    or  u_b2  (bw_s[2], g_s[2], t2a_s, t2b_s, t2c_s);
    and u_t3a (t3a_s, p_s[3], g_s[2]);
    and u_t3b (t3b_s, p_s[3], p_s[2], g_s[1]);
    and u_t3c (t3c_s, p_s[3], p_s[2], p_s[1], g_s[0]);
    and u_t3d (t3d_s, p_s[3], p_s[2], p_s[1], p_s[0], bi);
    or  u_b3  (bw_s[3], g_s[3], t3a_s, t3b_s, t3c_s, t3d_s);

    assign bin_s = {bw_s[NIB_W-2:0], bi};

    for (genvar k = 0; k < NIB_W; k++) begin : g_diff
        xor u_d (d[k], a[k], b[k], bin_s[k]);
    end

    assign bo = bw_s[NIB_W-1];
endmodule

// File: rtl/sub8_lookahead_pipe.sv
// Two-stage valid/ready 8-bit subtractor: low nibble in stage 1, high nibble in stage 2.
// Optional signed-overflow output enabled by defining SUB8_LOOKAHEAD_PIPE_OVF_EN.
module sub8_lookahead_pipe
    import sub_pkg::*;
#(
    parameter int PwrC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              bi,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] d,
    output logic              bo,
    output logic              out_valid,
    input  logic              out_ready
`ifdef SUB8_LOOKAHEAD_PIPE_OVF_EN
    ,
    output logic              ovf
`endif
);
    logic             s1_valid_r;
    logic [NIB_W-1:0] s1_dlo_r;
    logic             s1_blo_r;
    logic [NIB_W-1:0] s1_ahi_r;
    logic [NIB_W-1:0] s1_bhi_r;
    logic [NIB_W-1:0] dlo_s;
    logic             blo_s;
    logic [NIB_W-1:0] dhi_s;
    logic             bhi_s;
    logic             s2_adv_s;

    sub4_lookahead #(.PwrC(PwrC)) u_lo (
        .a  (a[NIB_W-1:0]),
        .b  (b[NIB_W-1:0]),
        .bi (bi),
        .d  (dlo_s),
        .bo (blo_s)
    );

    sub4_lookahead #(.PwrC(PwrC)) u_hi (
        .a  (s1_ahi_r),
        .b  (s1_bhi_r),
        .bi (s1_blo_r),
        .d  (dhi_s),
        .bo (bhi_s)
    );

    // Stage 1 may refill in the same cycle stage 2 hands its result downstream.
    assign s2_adv_s = !out_valid || out_ready;
    assign in_ready = !reset && (!s1_valid_r || s2_adv_s);

    // Stage 1: low-nibble result plus the high operands awaiting stage 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_dlo_r   <= {NIB_W{1'b0}};
            s1_blo_r   <= 1'b0;
            s1_ahi_r   <= {NIB_W{1'b0}};
            s1_bhi_r   <= {NIB_W{1'b0}};
        end else if (in_ready) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_dlo_r <= dlo_s;
                s1_blo_r <= blo_s;
                s1_ahi_r <= a[DATA_W-1:NIB_W];
                s1_bhi_r <= b[DATA_W-1:NIB_W];
            end
        end
    end

    // Stage 2: registered outputs, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            d         <= {DATA_W{1'b0}};
            bo        <= 1'b0;
`ifdef SUB8_LOOKAHEAD_PIPE_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (s2_adv_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                d  <= {dhi_s, s1_dlo_r};
                bo <= bhi_s;
`ifdef SUB8_LOOKAHEAD_PIPE_OVF_EN
                ovf <= (s1_ahi_r[NIB_W-1] ^ s1_bhi_r[NIB_W-1]) & (dhi_s[NIB_W-1] ^ s1_ahi_r[NIB_W-1]);
`endif
            end
        end
    end
endmodule

// File: tb/tb_sub8_lookahead_pipe.sv
// Directed and random self-checking bench for sub8_lookahead_pipe (with or without SUB8_LOOKAHEAD_PIPE_OVF_EN).
module tb_sub8_lookahead_pipe;
    import sub_pkg::*;

`ifdef SUB8_LOOKAHEAD_PIPE_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              bi;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] d;
    logic              bo;
    logic              out_valid;
    logic              out_ready;
    logic              ovf;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] va [8] = '{8'h20, 8'h05, 8'hFF, 8'h00, 8'h7F, 8'h9C, 8'h3C, 8'hA5};
    logic [7:0] vb [8] = '{8'h05, 8'h20, 8'hFF, 8'h00, 8'hFF, 8'h3A, 8'h0F, 8'h5A};
    logic       vc [8] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
    // Expected {ovf, bo, d}, worked out by hand.
    logic [9:0] ve [8] = '{10'h01B, 10'h1E5, 10'h1FF, 10'h000, 10'h380, 10'h261, 10'h02D, 10'h24A};

    sub8_lookahead_pipe #(.PwrC(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .bi        (bi),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .bo        (bo),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef SUB8_LOOKAHEAD_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

`ifndef SUB8_LOOKAHEAD_PIPE_OVF_EN
    assign ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] mask_ovf(input logic [9:0] v);
        return {v[9] & OVF_ON, v[8:0]};
    endfunction

    function automatic logic [9:0] obs_res();
        return {ovf & OVF_ON, bo, d};
    endfunction

    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] r;
        logic       o;
        r = {1'b0, x} - {1'b0, y} - {8'd0, c};
        o = (x[7] ^ y[7]) & (r[7] ^ x[7]);
        return mask_ovf({o, r[8], r[7:0]});
    endfunction

    task automatic run_one(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                           input logic xc, input logic [9:0] exp);
        @(negedge clk);
        a = xa; b = xb; bi = xc; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq({tag, "_early"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_res"}, 32'(obs_res()), 32'(mask_ovf(exp)));
    endtask

    initial begin
        int rx;
        int tx;
        logic seen;
        logic [9:0] q [$];
        logic [9:0] e;

        reset = 1'b1; a = 8'h00; b = 8'h00; bi = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out", 32'({out_valid, obs_res()}), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

        run_one("zero_minus_one", 8'h00, 8'h01, 1'b0, 10'h1FF);
        run_one("signed_ovf", 8'h80, 8'h01, 1'b0, 10'h27F);
        run_one("nibble_borrow", 8'h10, 8'h00, 1'b1, 10'h00F);

        // An operand accepted just before reset must never surface.
        @(negedge clk);
        a = 8'h55; b = 8'h22; bi = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check_eq("rst_flush", 32'(seen), 32'd0);
        run_one("after_rst", 8'h03, 8'h05, 1'b0, 10'h1FE);

        // Back-to-back stream with downstream stalled in cycles 3-5.
        rx = 0; tx = 0;
        for (int cyc = 0; cyc < 100 && rx < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid = (tx < 8);
            if (tx < 8) begin
                a = va[tx]; b = vb[tx]; bi = vc[tx];
            end
            #1;
            if (cyc >= 3 && cyc <= 5) begin
                check_eq("stall_in_ready", 32'(in_ready), 32'd0);
                check_eq("stall_hold", 32'({out_valid, obs_res()}), 32'({1'b1, mask_ovf(ve[1])}));
            end
            if (out_valid && out_ready) begin
                check_eq("stream_res", 32'(obs_res()), 32'(mask_ovf(ve[rx])));
                rx++;
            end
            if (in_valid && in_ready) tx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("stream_count", 32'(rx), 32'd8);

        // Random stream against the arithmetic reference model.
        rx = 0; tx = 0;
        for (int cyc = 0; cyc < 20000 && rx < 1000; cyc++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid = (tx < 1000) && ($urandom_range(0, 3) != 0);
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            bi = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check_eq("rand_spurious", 32'(q.size()), 32'd1);
                end else begin
                    e = q.pop_front();
                    check_eq("rand_res", 32'(obs_res()), 32'(e));
                end
                rx++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, bi));
                tx++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("rand_count", 32'(rx), 32'd1000);
        check_eq("rand_leftover", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
